serial_shift_master: RTL and testbench
======================================

Name: serial_shift_master

Overview:
Clocked controller that sequences the user module's serial shift-register port: drives sclk, the active-low chip enable ce and sin, and captures sout.
- Converts a parallel start/tx_data request into one framed DATA_W-bit transfer and returns the shifted-out word on rx_data.
- Sits between on-chip control logic, or the bench, and the shift-register datapath, replacing hand-toggled sclk/ce sequences.

Parameters:
DATA_W, 8, bits per transfer (>=2).
CLK_DIV, 1, clk cycles per sclk half-phase (>=1; 0 is an elaboration error).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request pulse or level; sampled only in IDLE.
tx_data  input  DATA_W  word to shift out, MSB first; latched on accepted start.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse at end of frame.
rx_data  output  DATA_W  word captured from sout; updated only with done.
sclk  output  1  serial clock to the datapath; idles high.
ce  output  1  active-low chip enable to the datapath; idles high.
sin  output  1  serial data to the datapath.
sout  input  1  serial data from the datapath.

Behaviour:
- Reset (async, reset=0): state IDLE; sclk=1, ce=1, sin=0, busy=0, done=0, rx_data=0; counters cleared. Asserting reset mid-frame aborts immediately with no done pulse.
- States: IDLE -> SETUP -> LOW <-> HIGH -> TRAIL -> IDLE. D = CLK_DIV.
  - IDLE: on start=1, latch tx_data into the tx shift register. Next cycle: ce=0, busy=1, state SETUP.
  - SETUP: hold sclk=1, ce=0 for D cycles, then enter LOW.
  - LOW: sclk=0; sin = current MSB of the tx shift register, stable for the whole phase. After D cycles, enter HIGH.
  - HIGH: sclk=1.
    - On the clk edge entering HIGH, sample sout into the rx shift register LSB; the datapath samples sin on the same sclk rise.
    - After D cycles: if bit count < DATA_W, shift tx and enter LOW; otherwise enter TRAIL.
  - TRAIL: sclk=1, ce=0 for 2*D cycles. Then in one cycle: ce=1, busy=0, done=1, rx_data updated. State returns to IDLE.
- Latency: from the cycle after start acceptance to the done cycle is D*(2*DATA_W+3) cycles.
- start while busy is ignored; no queuing.
- start held high in IDLE on the done cycle is not accepted until the next cycle. Back-to-back frames have at least one IDLE cycle with ce=1.
- sin returns to 0 in TRAIL and IDLE.
- rx_data holds its value between frames.
- Bit counter width is $clog2(DATA_W+1); the phase counter width is $clog2(2*D+1). Neither counter wraps within a frame.

Optional Feature:
ABORT_EN
- Defined: adds input port abort (1 bit). In SETUP, LOW or HIGH, abort=1 forces TRAIL on the next edge, with sclk=1. The frame then ends normally with done=1, and rx_data holds the partially shifted word, left-aligned zeros excluded (raw shift register). abort in IDLE or TRAIL has no effect.
- Undefined: no abort port; frames always run DATA_W bits.

Decomposition:
- Package serial_shift_pkg: state enum type (IDLE, SETUP, LOW, HIGH, TRAIL), default DATA_W/CLK_DIV constants, trail-length multiplier constant (2).
- One sub-module, sclk_phase_timer: CLK_DIV-based down-counter that emits a one-cycle phase_end tick and is reloaded on each state change. The FSM and shift registers stay in serial_shift_master.

Test Plan:
- Reset values: hold reset=0 for 3 clks -> sclk=1, ce=1, sin=0, busy=0, done=0, rx_data=0.
- Loopback, DATA_W=8, CLK_DIV=1, sout tied to sin, start with tx_data=8'h96 -> sin sequence 1,0,0,1,0,1,1,0 on sclk rises; done exactly 19 cycles after acceptance; rx_data=8'h96.
- CLK_DIV=3, sout held 1, tx_data=8'h00 -> each sclk phase is 3 clks wide; rx_data=8'hFF; busy high for 57 cycles.
- start pulsed again mid-frame with tx_data=8'h55 -> ignored; the first frame completes unchanged; a new start after done is accepted; ce is high for at least 1 cycle between frames.
- reset=0 asserted during bit 4 -> same cycle: ce=1, sclk=1, busy=0, no done pulse; rx_data keeps its pre-frame value.
- ABORT_EN defined, abort=1 during bit 2 -> TRAIL follows (2*D cycles, sclk=1), then done=1. Without the macro, the port is absent and the design elaborates cleanly.

Source files
------------

// File: rtl/serial_shift_pkg.sv
// ---------------------------------------------------------------------------
// serial_shift_pkg
// Shared types and constants for serial_shift_master and its phase timer.
//   state_t          : frame sequencer states
//   DEFAULT_DATA_W   : default bits per transfer
//   DEFAULT_CLK_DIV  : default clk cycles per sclk half-phase
//   TRAIL_MULT       : TRAIL phase length in units of CLK_DIV
// ---------------------------------------------------------------------------
package serial_shift_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        TRAIL = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_CLK_DIV = 1;
    localparam int TRAIL_MULT      = 2;

endpackage

// File: rtl/serial_shift_master_sclk_phase_timer.sv
// ---------------------------------------------------------------------------
// sclk_phase_timer
// Down-counter that measures how long the sequencer stays in one state.
// Reloaded on every state change; o_phase_end is high in the last cycle of
// the phase.
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_load      : reload the counter (state is changing this edge)
//   i_long      : the phase being entered is TRAIL (TRAIL_MULT*CLK_DIV long)
//   o_phase_end : current phase has reached its final cycle
// ---------------------------------------------------------------------------
module sclk_phase_timer
    import serial_shift_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_long,
    output logic o_phase_end
);

    localparam int CNT_W = $clog2(TRAIL_MULT * CLK_DIV + 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(TRAIL_MULT * CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Loading N-1 makes the phase last N cycles: the counter reaches zero in
    // the Nth cycle and the sequencer leaves the state on the following edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_long ? LONG_LOAD : SHORT_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_phase_end = (r_cnt == '0);

endmodule

// File: rtl/serial_shift_master.sv
// ---------------------------------------------------------------------------
// serial_shift_master
// Sequences one framed DATA_W-bit transfer on a serial shift-register port:
// drives sclk (idles high), active-low ce and sin (MSB first) and captures
// sout on each sclk rise. The captured word appears on o_rx_data together
// with the one-cycle o_done pulse.
//   i_clk      : system clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_start    : transfer request, sampled only in IDLE
//   i_tx_data  : word to send, latched when i_start is accepted
//   i_abort    : (ABORT_EN only) cut the frame short into TRAIL
//   o_busy     : frame in progress
//   o_done     : one-cycle end-of-frame pulse
//   o_rx_data  : last captured word, updated with o_done
//   o_sclk     : serial clock to the datapath
//   o_ce       : active-low chip enable to the datapath
//   o_sin      : serial data to the datapath
//   i_sout     : serial data from the datapath
// Optional build macro: ABORT_EN adds the i_abort port.
// ---------------------------------------------------------------------------
module serial_shift_master
    import serial_shift_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
`ifdef ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_sclk,
    output logic              o_ce,
    output logic              o_sin,
    input  logic              i_sout
);

    generate
        if (DATA_W < 2) begin : g_bad_data_w
            $error("serial_shift_master: DATA_W must be at least 2");
        end
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("serial_shift_master: CLK_DIV must be at least 1");
        end
    endgenerate

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_done;
    logic              w_accept;
    logic              w_abort;
    logic              w_phase_end;
    logic              w_load;

`ifdef ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state logic. The done cycle is already IDLE, but a start seen in
    // that cycle is refused so consecutive frames always have a ce-high gap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !r_done) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                if (w_abort)          w_state_next = TRAIL;
                else if (w_phase_end) w_state_next = LOW;
            end
            LOW: begin
                if (w_abort)          w_state_next = TRAIL;
                else if (w_phase_end) w_state_next = HIGH;
            end
            HIGH: begin
                if (w_abort) begin
                    w_state_next = TRAIL;
                end else if (w_phase_end) begin
                    // r_bit_cnt already includes the bit sampled entering HIGH
                    w_state_next = (r_bit_cnt < BIT_LAST) ? LOW : TRAIL;
                end
            end
            TRAIL: begin
                if (w_phase_end) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Pin outputs decode straight from the state register so an asynchronous
    // reset returns the port to its idle levels in the same cycle.
    always_comb begin
        o_sclk = 1'b1;
        o_ce   = 1'b1;
        o_busy = 1'b0;
        o_sin  = 1'b0;
        case (r_state)
            SETUP: begin
                o_ce   = 1'b0;
                o_busy = 1'b1;
            end
            LOW: begin
                o_sclk = 1'b0;
                o_ce   = 1'b0;
                o_busy = 1'b1;
                o_sin  = r_tx_sr[DATA_W-1];
            end
            HIGH: begin
                // sin is held through HIGH so it does not move at the sclk rise
                o_ce   = 1'b0;
                o_busy = 1'b1;
                o_sin  = r_tx_sr[DATA_W-1];
            end
            TRAIL: begin
                o_ce   = 1'b0;
                o_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;

    assign w_load = (w_state_next != r_state);

    sclk_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_long      (w_state_next == TRAIL),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;

            if (w_accept) begin
                r_tx_sr   <= i_tx_data;
                r_rx_sr   <= '0;
                r_bit_cnt <= '0;
            end

            // Capture on the edge that raises sclk
            if (r_state == LOW && w_state_next == HIGH) begin
                r_rx_sr   <= {r_rx_sr[DATA_W-2:0], i_sout};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            // Present the next bit only when sclk falls again
            if (r_state == HIGH && w_state_next == LOW) begin
                r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
            end

            if (r_state == TRAIL && w_state_next == IDLE) begin
                r_done    <= 1'b1;
                r_rx_data <= r_rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_master.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_master
// Two instances: index 0 with CLK_DIV=1, index 1 with CLK_DIV=3, both
// DATA_W=8. The reference model works from the frame rules: a frame lasts
// D*(2*W+3) cycles, sends tx MSB first, and returns the sout bit present at
// the end of each sclk-low phase.
// ---------------------------------------------------------------------------
module tb_serial_shift_master;

    localparam int W    = 8;
    localparam int DIV0 = 1;
    localparam int DIV1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_n;
    logic [1:0]        start;
    logic [1:0][W-1:0] tx_data;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [1:0][W-1:0] rx_data;
    logic [1:0]        sclk;
    logic [1:0]        ce;
    logic [1:0]        sin;
    logic [1:0]        sout;
    logic [1:0][1:0]   sout_mode;   // 0 loopback, 1 random, 2 const 1, 3 const 0
    logic [1:0]        sout_rand;
    logic [1:0]        abort;

    int total = 0;
    int bad   = 0;

    always_comb begin
        sout = '0;
        for (int k = 0; k < 2; k++) begin
            case (sout_mode[k])
                2'd0:    sout[k] = sin[k];
                2'd1:    sout[k] = sout_rand[k];
                2'd2:    sout[k] = 1'b1;
                default: sout[k] = 1'b0;
            endcase
        end
    end

    serial_shift_master #(.DATA_W(W), .CLK_DIV(DIV0)) u_dut0 (
        .i_clk     (clk),
        .i_rst_n   (rst_n[0]),
        .i_start   (start[0]),
        .i_tx_data (tx_data[0]),
`ifdef ABORT_EN
        .i_abort   (abort[0]),
`endif
        .o_busy    (busy[0]),
        .o_done    (done[0]),
        .o_rx_data (rx_data[0]),
        .o_sclk    (sclk[0]),
        .o_ce      (ce[0]),
        .o_sin     (sin[0]),
        .i_sout    (sout[0])
    );

    serial_shift_master #(.DATA_W(W), .CLK_DIV(DIV1)) u_dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n[1]),
        .i_start   (start[1]),
        .i_tx_data (tx_data[1]),
`ifdef ABORT_EN
        .i_abort   (abort[1]),
`endif
        .o_busy    (busy[1]),
        .o_done    (done[1]),
        .o_rx_data (rx_data[1]),
        .o_sclk    (sclk[1]),
        .o_ce      (ce[1]),
        .o_sin     (sin[1]),
        .i_sout    (sout[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? DIV0 : DIV1;
    endfunction

    // Observes one frame starting just after its acceptance edge and returns
    // at the negedge inside the done cycle. If poke is set, a second start
    // with tx 8'h55 is raised mid-frame and left high.
    task automatic watch_frame(input int k, input logic [W-1:0] tx, input bit poke);
        int d        = div_of(k);
        int len      = d * (2 * W + 3);
        int cyc      = 0;
        int busy_n   = 0;
        int ce_n     = 0;
        int low_n    = 0;
        int bad_w    = 0;
        int run      = 0;
        int hi_run   = 0;
        int unstable = 0;
        int rx_moved = 0;
        bit prev_sclk = 1'b1;
        bit got       = 1'b0;
        logic cur_sin = 1'b0;
        logic [W-1:0] sin_word = '0;
        logic [W-1:0] rnd_word = '0;
        logic [W-1:0] rx_before = rx_data[k];
        logic [W-1:0] exp_rx;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin
                start[k]   = 1'b1;
                tx_data[k] = 8'h55;
            end
            if (done[k]) begin
                got = 1'b1;
            end else begin
                if (busy[k]) busy_n++;
                if (!ce[k])  ce_n++;
                if (rx_data[k] !== rx_before) rx_moved++;
                if (!sclk[k]) begin
                    if (prev_sclk) begin
                        low_n++;
                        run     = 0;
                        cur_sin = sin[k];
                        sout_rand[k] = 1'($urandom_range(0, 1));
                        rnd_word = {rnd_word[W-2:0], sout_rand[k]};
                    end else if (sin[k] !== cur_sin) begin
                        unstable++;
                    end
                    run++;
                    hi_run = 0;
                end else begin
                    if (!prev_sclk) begin
                        if (run != d) bad_w++;
                        sin_word = {sin_word[W-2:0], cur_sin};
                    end
                    hi_run++;
                end
                prev_sclk = sclk[k];
            end
        end
        case (sout_mode[k])
            2'd0:    exp_rx = tx;
            2'd1:    exp_rx = rnd_word;
            2'd2:    exp_rx = '1;
            default: exp_rx = '0;
        endcase
        check("done_seen",   32'(got),       32'd1);
        check("latency",     32'(cyc - 1),   32'(len));
        check("busy_cycles", 32'(busy_n),    32'(len));
        check("ce_low",      32'(ce_n),      32'(len));
        check("low_phases",  32'(low_n),     32'(W));
        check("low_width",   32'(bad_w),     32'd0);
        check("sin_stable",  32'(unstable),  32'd0);
        check("trail_high",  32'(hi_run),    32'(3 * d));
        check("sin_word",    32'(sin_word),  32'(tx));
        check("rx_early",    32'(rx_moved),  32'd0);
        check("done_ce",     32'(ce[k]),     32'd1);
        check("done_busy",   32'(busy[k]),   32'd0);
        check("done_sin",    32'(sin[k]),    32'd0);
        check("rx_data",     32'(rx_data[k]), 32'(exp_rx));
        $display("frame dut=%0d div=%0d tx=%02h mode=%0d rx=%02h exp=%02h lat=%0d",
                 k, d, tx, sout_mode[k], rx_data[k], exp_rx, cyc - 1);
    endtask

    task automatic run_frame(input int k, input logic [W-1:0] tx, input logic [1:0] mode);
        logic [W-1:0] rx_done;
        sout_mode[k] = mode;
        @(negedge clk);
        start[k]   = 1'b1;
        tx_data[k] = tx;
        @(posedge clk);
        #1;
        start[k]   = 1'b0;
        tx_data[k] = W'($urandom);
        watch_frame(k, tx, 1'b0);
        rx_done = rx_data[k];
        @(negedge clk);
        check("done_pulse", 32'(done[k]),    32'd0);
        check("rx_hold",    32'(rx_data[k]), 32'(rx_done));
    endtask

    initial begin
        int dn;
        rst_n     = '0;
        start     = '0;
        tx_data   = '0;
        sout_mode = '0;
        sout_rand = '0;
        abort     = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_sclk%0d", k), 32'(sclk[k]),    32'd1);
            check($sformatf("rst_ce%0d", k),   32'(ce[k]),      32'd1);
            check($sformatf("rst_sin%0d", k),  32'(sin[k]),     32'd0);
            check($sformatf("rst_busy%0d", k), 32'(busy[k]),    32'd0);
            check($sformatf("rst_done%0d", k), 32'(done[k]),    32'd0);
            check($sformatf("rst_rx%0d", k),   32'(rx_data[k]), 32'd0);
        end
        rst_n = '1;
        @(negedge clk);

        // Frame that leaves rx_data at zero, then a reset during bit 4
        run_frame(0, 8'h00, 2'd0);
        sout_mode[0] = 2'd0;
        @(negedge clk);
        start[0]   = 1'b1;
        tx_data[0] = 8'hC5;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_bit4_low", 32'(sclk[0]), 32'd0);
        #1;
        rst_n[0] = 1'b0;
        #1;
        check("mid_rst_ce",   32'(ce[0]),      32'd1);
        check("mid_rst_sclk", 32'(sclk[0]),    32'd1);
        check("mid_rst_busy", 32'(busy[0]),    32'd0);
        check("mid_rst_done", 32'(done[0]),    32'd0);
        check("mid_rst_sin",  32'(sin[0]),     32'd0);
        check("mid_rst_rx",   32'(rx_data[0]), 32'd0);
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (done[0]) dn++;
        end
        rst_n[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done[0] || !ce[0]) dn++;
        end
        check("mid_rst_quiet", 32'(dn), 32'd0);

        // Loopback 8'h96 at D=1 and all-ones capture at D=3
        run_frame(0, 8'h96, 2'd0);
        run_frame(1, 8'h00, 2'd2);

        // start re-asserted mid-frame and held through done
        sout_mode[0] = 2'd0;
        @(negedge clk);
        start[0]   = 1'b1;
        tx_data[0] = 8'hA3;
        @(posedge clk);
        watch_frame(0, 8'hA3, 1'b1);
        @(negedge clk);
        check("gap_ce",   32'(ce[0]),   32'd1);
        check("gap_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        watch_frame(0, 8'h55, 1'b0);
        @(negedge clk);

        // Randomized frames on both instances
        for (int i = 0; i < 8; i++) begin
            run_frame(i % 2, W'($urandom), 2'($urandom_range(0, 1)));
        end

`ifdef ABORT_EN
        // Abort during bit 2 at D=3 with sout held high: bits 0 and 1 captured
        begin
            int tcyc = 0;
            int hi_bad = 0;
            sout_mode[1] = 2'd2;
            @(negedge clk);
            start[1]   = 1'b1;
            tx_data[1] = 8'hF0;
            @(posedge clk);
            #1;
            start[1] = 1'b0;
            repeat (17) @(negedge clk);
            check("abort_in_low", 32'(sclk[1]), 32'd0);
            abort[1] = 1'b1;
            @(posedge clk);
            #1;
            abort[1] = 1'b0;
            while (tcyc < 50) begin
                @(negedge clk);
                tcyc++;
                if (done[1]) break;
                if (!sclk[1] || ce[1]) hi_bad++;
            end
            check("abort_trail_len", 32'(tcyc),       32'(2 * DIV1 + 1));
            check("abort_trail_lvl", 32'(hi_bad),     32'd0);
            check("abort_done",      32'(done[1]),    32'd1);
            check("abort_rx",        32'(rx_data[1]), 32'h03);
            $display("abort dut=1 rx=%02h trail=%0d", rx_data[1], tcyc - 1);
            @(negedge clk);
            check("abort_done_pulse", 32'(done[1]), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
